picture_crop_win: RTL

// - Runtime-programmable crop window on the gmii_rx_clk pixel stream (UDP video receive -> DDR write path).
// - Tracks X/Y position of every valid pixel in a FRAME_W x FRAME_H frame.
// - Passes only pixels inside the window, tagged with SOF/EOL/EOF markers for the DDR write master.
// - Adds over its fixed-window predecessor:
//   - shadowed config
//   - pixel data path
//   - optional SOF resync
//   - config/sync error flags
//   - 2:1 decimation

---
 rtl/video_pkg.sv | 7 +
 rtl/picture_crop_win_if.sv | 13 +
 rtl/pix_pos_counter.sv | 30 +++
 rtl/picture_crop_win.sv | 84 ++++++++
 4 files changed

// File: rtl/video_pkg.sv
// video_pkg: shared counter width, default frame geometry and crop FSM encoding
package video_pkg;
  localparam int CNT_W       = 11;
  localparam int FRAME_W_DEF = 800;
  localparam int FRAME_H_DEF = 480;
  typedef enum logic {WAIT_SOF = 1'b0, RUN = 1'b1} crop_state_t;
endpackage

// File: rtl/picture_crop_win_if.sv
// picture_crop_win_if: input pixel stream and cropped output stream with SOF/EOL/EOF markers
interface picture_crop_win_if #(parameter int DATA_W = 16) ();
  logic              pix_vld;
  logic              pix_sof;
  logic [DATA_W-1:0] pix_data;
  logic              crop_vld;
  logic              crop_sof;
  logic              crop_eol;
  logic              crop_eof;
  logic [DATA_W-1:0] crop_data;
  modport master (output pix_vld, pix_sof, pix_data, input crop_vld, crop_sof, crop_eol, crop_eof, crop_data);
  modport slave  (input pix_vld, pix_sof, pix_data, output crop_vld, crop_sof, crop_eol, crop_eof, crop_data);
endinterface

// File: rtl/pix_pos_counter.sv
// pix_pos_counter: x/y pixel position with runtime wrap limits, load-to-origin and last-pixel flag
module pix_pos_counter #(parameter int CNT_W = 11) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_en,
  input  logic             i_zero,
  input  logic [CNT_W-1:0] i_lim_x,
  input  logic [CNT_W-1:0] i_lim_y,
  output logic [CNT_W-1:0] o_x,
  output logic [CNT_W-1:0] o_y,
  output logic [CNT_W-1:0] o_cx,
  output logic [CNT_W-1:0] o_cy,
  output logic             o_last
);
  logic w_last_x, w_last_y;
  // o_cx/o_cy: position of the pixel being accepted now, after an optional forced origin
  assign o_cx     = i_zero ? '0 : o_x;
  assign o_cy     = i_zero ? '0 : o_y;
  assign w_last_x = o_cx == i_lim_x - CNT_W'(1);
  assign w_last_y = o_cy == i_lim_y - CNT_W'(1);
  assign o_last   = w_last_x & w_last_y;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      o_x <= '0;
      o_y <= '0;
    end else if (i_en) begin
      o_x <= w_last_x ? '0 : o_cx + CNT_W'(1);
      o_y <= w_last_x ? (w_last_y ? '0 : o_cy + CNT_W'(1)) : o_cy;
    end
endmodule

// File: rtl/picture_crop_win.sv
// picture_crop_win: runtime crop window with shadowed config, 2:1 decimation and SOF resync
module picture_crop_win #(
  parameter int DATA_W   = 16,
  parameter int CNT_W    = video_pkg::CNT_W,
  parameter bit SOF_SYNC = 1'b1
) (
  input  logic             gmii_rx_clk,
  input  logic             sys_rst_n,
  picture_crop_win_if.slave bus,
  input  logic [CNT_W-1:0] frame_w,
  input  logic [CNT_W-1:0] frame_h,
  input  logic [CNT_W-1:0] win_x0,
  input  logic [CNT_W-1:0] win_y0,
  input  logic [CNT_W-1:0] win_w,
  input  logic [CNT_W-1:0] win_h,
  input  logic             dec_en,
  output logic [CNT_W-1:0] pix_cntx,
  output logic [CNT_W-1:0] pix_cnty,
  output logic             frame_done,
  output logic             cfg_err,
  output logic             sync_err
);
  video_pkg::crop_state_t r_state;
  logic [CNT_W-1:0] r_fw, r_fh, r_x0, r_y0, r_w, r_h;
  logic r_dec;
  logic [CNT_W-1:0] w_fw, w_fh, w_x0, w_y0, w_w, w_h, w_cx, w_cy, w_lx, w_ly;
  logic [CNT_W:0] w_xe, w_ye;
  logic [DATA_W-1:0] w_pix;
  logic w_acc, w_org, w_dec, w_last, w_err, w_in, w_keep;
  assign w_pix = bus.pix_data;
  assign w_acc = bus.pix_vld & (r_state == video_pkg::RUN | bus.pix_sof);
  pix_pos_counter #(.CNT_W(CNT_W)) u_pos (
    .clk(gmii_rx_clk), .rst_n(sys_rst_n), .i_en(w_acc), .i_zero(bus.pix_sof),
    .i_lim_x(w_fw), .i_lim_y(w_fh), .o_x(pix_cntx), .o_y(pix_cnty),
    .o_cx(w_cx), .o_cy(w_cy), .o_last(w_last)
  );
  // The origin pixel already uses the live geometry it is about to shadow
  assign w_org = w_acc & w_cx == '0 & w_cy == '0;
  assign w_fw  = w_org ? frame_w : r_fw;
  assign w_fh  = w_org ? frame_h : r_fh;
  assign w_x0  = w_org ? win_x0 : r_x0;
  assign w_y0  = w_org ? win_y0 : r_y0;
  assign w_w   = w_org ? win_w : r_w;
  assign w_h   = w_org ? win_h : r_h;
  assign w_dec = w_org ? dec_en : r_dec;
  assign w_xe  = {1'b0, w_x0} + {1'b0, w_w};
  assign w_ye  = {1'b0, w_y0} + {1'b0, w_h};
  assign w_err = w_w == '0 | w_h == '0 | w_xe > {1'b0, w_fw} | w_ye > {1'b0, w_fh};
  // With decimation an even-sized span ends one short, on the x0/y0 parity
  assign w_lx  = w_x0 + w_w - CNT_W'(1) - CNT_W'(w_dec & ~w_w[0]);
  assign w_ly  = w_y0 + w_h - CNT_W'(1) - CNT_W'(w_dec & ~w_h[0]);
  assign w_in  = w_cx >= w_x0 & {1'b0, w_cx} < w_xe & w_cy >= w_y0 & {1'b0, w_cy} < w_ye &
                 (~w_dec | (w_cx[0] == w_x0[0] & w_cy[0] == w_y0[0]));
  assign w_keep = w_acc & w_in & ~w_err;
  always_ff @(posedge gmii_rx_clk or negedge sys_rst_n)
    if (!sys_rst_n) begin
      r_state <= SOF_SYNC ? video_pkg::WAIT_SOF : video_pkg::RUN;
      {r_fw, r_fh, r_x0, r_y0, r_w, r_h} <= '0;
      r_dec         <= 1'b0;
      cfg_err       <= 1'b0;
      sync_err      <= 1'b0;
      frame_done    <= 1'b0;
      bus.crop_vld  <= 1'b0;
      bus.crop_data <= '0;
      bus.crop_sof  <= 1'b0;
      bus.crop_eol  <= 1'b0;
      bus.crop_eof  <= 1'b0;
    end else begin
      if (w_acc) r_state <= video_pkg::RUN;
      if (w_org) begin
        {r_fw, r_fh, r_x0, r_y0, r_w, r_h} <= {frame_w, frame_h, win_x0, win_y0, win_w, win_h};
        r_dec   <= dec_en;
        cfg_err <= w_err;
      end
      if (w_acc & bus.pix_sof & r_state == video_pkg::RUN & (pix_cntx != '0 | pix_cnty != '0))
        sync_err <= 1'b1;
      frame_done   <= w_acc & w_last;
      bus.crop_vld <= w_keep;
      if (w_keep) bus.crop_data <= w_pix;
      bus.crop_sof <= w_keep & w_cx == w_x0 & w_cy == w_y0;
      bus.crop_eol <= w_keep & w_cx == w_lx;
      bus.crop_eof <= w_keep & w_cx == w_lx & w_cy == w_ly;
    end
endmodule
